instr_issue_unit: RTL
=====================

// Module: instr_issue_unit
// PURPOSE
//  Fetch/issue front end feeding the control unit: fetches 32-bit instruction words, splits op/cond/imm,
//  presents them beat by beat, holds multi-beat vector/histogram ops, and redirects PC on B/BNQ.
//  Sits between instruction memory and the decode stage; the producer end of the op/cond interface.
// PARAMETERS
//  ADDR_W     10         instruction address width (word addressed)
//  RESET_PC   0          PC loaded on reset
//  VEC_BEATS  8          beats for LOAD_8X8/STORE_8X8/MODS_8X8/GET8X8 (one per row)
//  HIST_BEATS 4          beats for INC1_4X16/NORM_4X16/MULS_4X16
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  imem_req     out  1       fetch request, held until imem_valid
//  imem_addr    out  ADDR_W  fetch address (= pc)
//  imem_valid   in   1       instruction word valid (one response per request)
//  imem_rdata   in   32      instruction word
//  issue_valid  out  1       op/cond/imm/beat_idx valid to decode
//  issue_ready  in   1       decode accepts current beat
//  op           out  4       instr[31:28]
//  cond         out  1       instr[27]
//  imm          out  16      instr[15:0]
//  beat_idx     out  3       current beat (row/lane group) of a multi-beat op
//  zero_flag    in   1       Z flag from execute, sampled at BNQ acceptance
//  halted       out  1       HALT (op 4'b1111) retired; front end frozen
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, imem_req=0, issue_valid=0, op=4'b0000, cond=0, imm=0, beat_idx=0, halted=0.
//  States: IDLE -> FETCH (1 cycle after rst deasserts); FETCH: imem_req=1, imem_addr=pc; on imem_valid
//   latch word, -> ISSUE next cycle (op etc. registered, issue_valid=1). ISSUE: hold outputs stable while
//   issue_valid && !issue_ready. Each accepted beat increments beat_idx; last beat -> FETCH with new pc.
//  Beat count: 8X8 ops (0110,0111,1000,1100) VEC_BEATS; 4X16 ops (1001,1010,1011) HIST_BEATS; all others 1.
//  Next pc on last-beat acceptance: B (0100): pc+1+sext(imm); BNQ (0101): zero_flag==0 ? pc+1+sext(imm)
//   : pc+1; HALT (1111): pc unchanged, -> HALT state, halted=1, no further requests; else pc+1.
//  PC arithmetic modulo 2^ADDR_W (pc=all-ones +1 wraps to 0; branch targets wrap likewise).
//  Opcodes 0000/1101 issue as 1-beat NOPs (decode defaults them). beat_idx resets to 0 on every new op.
//  Throughput: fetch latency L -> min 1+L+beats cycles/instr; no prefetch, so branches need no flush.
//  imem_valid outside FETCH ignored. rst in any state (incl. mid-beat or outstanding fetch) returns to
//   reset values next edge; a late imem_valid for the aborted fetch is ignored unless in FETCH again
//   (memory must drop outstanding responses on rst). HALT exits only via rst.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined: adds outputs cyc_cnt[31:0] (counts every non-reset cycle not in HALT)
//   and ret_cnt[31:0] (increments on each last-beat acceptance, incl. HALT); both 0 on rst, wrap at 2^32.
//  Undefined: ports and counters absent; functional behaviour otherwise identical.
// STRUCTURE
//  Shared package proc_pkg: opcode_e enum (MOV=1110, INC=0001, ADD=0010, CMP=0011, B=0100, BNQ=0101,
//   LOAD_8X8=0110, STORE_8X8=0111, MODS_8X8=1000, INC1_4X16=1001, NORM_4X16=1010, MULS_4X16=1011,
//   GET8X8=1100, HALT=1111), instruction field localparams, issue_state_e, beats_for(op) function.
//  One sub-module: issue_beat_counter (load beats, decrement on accept, last flag, beat_idx).
// TESTING
//  Reset then imem returns ADD (0x2xxxxxxx) at addr 0 with 1-cycle latency, ready=1 -> op=0010 one beat,
//   next imem_addr=1.
//  LOAD_8X8 with issue_ready toggling 1/0 -> beat_idx 0..7, outputs stable while stalled, exactly 8 accepts.
//  pc=5, BNQ imm=0xFFFC: zero_flag=0 -> next addr 2; zero_flag=1 -> next addr 6.
//  B at pc=2^ADDR_W-1 imm=0x0001 -> next addr 1 (wrap); INC at all-ones -> next addr 0.
//  rst asserted at beat 3 of NORM_4X16 with fetch pending -> all outputs reset next cycle, fetch from RESET_PC.
//  HALT at addr 4 -> halted=1, imem_req stays 0 for 20 cycles; with ISSUE_PERF_CNT_EN ret_cnt=5 after 5 instrs.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcodes, instruction field positions, issue FSM states
// and the beats-per-opcode helper used by the fetch/issue front end.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'b0000,
    OP_INC       = 4'b0001,
    OP_ADD       = 4'b0010,
    OP_CMP       = 4'b0011,
    OP_B         = 4'b0100,
    OP_BNQ       = 4'b0101,
    OP_LOAD_8X8  = 4'b0110,
    OP_STORE_8X8 = 4'b0111,
    OP_MODS_8X8  = 4'b1000,
    OP_INC1_4X16 = 4'b1001,
    OP_NORM_4X16 = 4'b1010,
    OP_MULS_4X16 = 4'b1011,
    OP_GET8X8    = 4'b1100,
    OP_RSVD      = 4'b1101,
    OP_MOV       = 4'b1110,
    OP_HALT      = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } issue_state_e;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 28;
  localparam int COND_BIT   = 27;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int BEAT_CNT_W = 4;

  // Row-wise 8x8 ops and 4x16 histogram ops occupy several issue beats; everything else one.
  function automatic logic [BEAT_CNT_W-1:0] beats_for(
    input logic [3:0]            op,
    input logic [BEAT_CNT_W-1:0] vec_beats,
    input logic [BEAT_CNT_W-1:0] hist_beats
  );
    case (op)
      OP_LOAD_8X8, OP_STORE_8X8, OP_MODS_8X8, OP_GET8X8: beats_for = vec_beats;
      OP_INC1_4X16, OP_NORM_4X16, OP_MULS_4X16:          beats_for = hist_beats;
      default:                                           beats_for = BEAT_CNT_W'(1);
    endcase
  endfunction

endpackage

// File: rtl/issue_beat_counter.sv
// Tracks the remaining issue beats of the current op and exposes the beat index
// (row / lane group) plus a flag marking the final beat.
module issue_beat_counter
  import proc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BEAT_CNT_W-1:0] beats,
  input  logic                  accept,
  output logic                  last,
  output logic [2:0]            beat_idx
);

  logic [BEAT_CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      beat_idx  <= '0;
    end else if (load) begin
      remaining <= beats;
      beat_idx  <= '0;
    end else if (accept) begin
      if (last) begin
        remaining <= '0;
        beat_idx  <= '0;
      end else begin
        remaining <= remaining - BEAT_CNT_W'(1);
        beat_idx  <= beat_idx + 3'd1;
      end
    end
  end

  assign last = (remaining <= BEAT_CNT_W'(1));

endmodule

// File: rtl/instr_issue_unit.sv
// Fetch/issue front end: fetches one word at a time, issues it beat by beat and redirects on B/BNQ.
// Define ISSUE_PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counter outputs.
module instr_issue_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RESET_PC   = 0,
  parameter int VEC_BEATS  = 8,
  parameter int HIST_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [3:0]        op,
  output logic              cond,
  output logic [15:0]       imm,
  output logic [2:0]        beat_idx,
  input  logic              zero_flag,
  output logic              halted
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  issue_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] imm_ext;
  logic              load_word;
  logic              accept;
  logic              last_beat;
  logic              retire;

  assign imem_addr = pc;
  assign load_word = (state == S_FETCH) && imem_valid;
  assign accept    = issue_valid && issue_ready;
  assign retire    = accept && last_beat;

  issue_beat_counter u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_word),
    .beats    (beats_for(imem_rdata[OP_MSB:OP_LSB], BEAT_CNT_W'(VEC_BEATS), BEAT_CNT_W'(HIST_BEATS))),
    .accept   (accept),
    .last     (last_beat),
    .beat_idx (beat_idx)
  );

  // Branch offsets are sign-extended (or truncated) to the PC width so targets wrap naturally.
  always_comb begin
    imm_ext = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      imm_ext[i] = (i < 16) ? imm[i[3:0]] : imm[15];
    end
    pc_inc  = pc + ADDR_W'(1);
    pc_tgt  = pc_inc + imm_ext;
    next_pc = pc_inc;
    case (op)
      OP_B:    next_pc = pc_tgt;
      OP_BNQ:  if (!zero_flag) next_pc = pc_tgt;
      OP_HALT: next_pc = pc;
      default: next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= ADDR_W'(RESET_PC);
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
      op          <= 4'b0000;
      cond        <= 1'b0;
      imm         <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_valid) begin
            op          <= imem_rdata[OP_MSB:OP_LSB];
            cond        <= imem_rdata[COND_BIT];
            imm         <= imem_rdata[IMM_MSB:IMM_LSB];
            imem_req    <= 1'b0;
            issue_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // No prefetch: the next fetch starts only once the final beat is taken.
          if (retire) begin
            issue_valid <= 1'b0;
            if (op == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
              pc       <= next_pc;
            end
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire)          ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule
